// File: rtl/seq_alu_pkg.sv
// Shared constants for seq_alu: opcodes, FSM state encoding and flag bit positions.
// The divide opcode is only decoded when SEQ_ALU_DIV_EN is defined.
package seq_alu_pkg;

    localparam int unsigned OpAdd  = 32'h04;
    localparam int unsigned OpSub  = 32'h05;
    localparam int unsigned OpNeg  = 32'h06;
    localparam int unsigned OpMul  = 32'h07;
    localparam int unsigned OpDiv  = 32'h08;
    localparam int unsigned OpOr   = 32'h09;
    localparam int unsigned OpXor  = 32'h0A;
    localparam int unsigned OpNand = 32'h0B;
    localparam int unsigned OpNor  = 32'h0C;
    localparam int unsigned OpXnor = 32'h0D;
    localparam int unsigned OpNot  = 32'h0E;
    localparam int unsigned OpShl  = 32'h0F;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned FlagZero    = 0;
    localparam int unsigned FlagCarry   = 1;
    localparam int unsigned FlagDivZero = 2;
    localparam int unsigned FlagIllegal = 3;

endpackage

// File: rtl/seq_alu_iter.sv
// Shared iterative datapath: shift-add multiply (mode 0) and restoring divide (mode 1),
// one bit per cycle. The divide section exists only when SEQ_ALU_DIV_EN is defined.
module seq_alu_iter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               mode_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] res_o
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic               busy_q, busy_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] step;
    logic [WIDTH-1:0]   mul_add;
    logic [WIDTH:0]     mul_sum;
    logic               load;

`ifdef SEQ_ALU_DIV_EN
    logic           mode_q, mode_d;
    logic [WIDTH:0] div_trial, div_diff;

    assign load = start_i;
`else
    // Divide requests are refused outright when the divider is not built.
    assign load = start_i && !mode_i;
`endif

    assign done_o = busy_q && (cnt_q == CntW'(WIDTH - 1));
    assign res_o  = step;

    always_comb begin
        mul_add = acc_q[0] ? opnd_q : {WIDTH{1'b0}};
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
        step    = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
        div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_trial - {1'b0, opnd_q};
        if (mode_q) begin
            if (!div_diff[WIDTH]) begin
                step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        opnd_d = opnd_q;
        acc_d  = acc_q;
`ifdef SEQ_ALU_DIV_EN
        mode_d = mode_q;
`endif
        if (load) begin
            busy_d = 1'b1;
            cnt_d  = '0;
`ifdef SEQ_ALU_DIV_EN
            mode_d = mode_i;
            opnd_d = mode_i ? b_i : a_i;
            acc_d  = {{WIDTH{1'b0}}, (mode_i ? a_i : b_i)};
`else
            opnd_d = a_i;
            acc_d  = {{WIDTH{1'b0}}, b_i};
`endif
        end else if (busy_q) begin
            acc_d = step;
            cnt_d = cnt_q + CntW'(1);
            if (done_o) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            opnd_q <= '0;
            acc_q  <= '0;
`ifdef SEQ_ALU_DIV_EN
            mode_q <= 1'b0;
`endif
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            opnd_q <= opnd_d;
            acc_q  <= acc_d;
`ifdef SEQ_ALU_DIV_EN
            mode_q <= mode_d;
`endif
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative MUL and optional DIV.
// Define SEQ_ALU_DIV_EN to build the divider; otherwise opcode 0x08 is illegal.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OPW   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OPW-1:0]     opcode,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic [3:0]         flags
);

    localparam int unsigned ShW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic [3:0]         flags_q, flags_d;

    logic [31:0]        opc;
    logic [WIDTH-1:0]   alu_lo, alu_hi;
    logic               alu_cy, alu_ill, alu_dz;
    logic [WIDTH:0]     add_sum, shl_full;
    logic               use_iter, iter_mode, iter_start, iter_done;
    logic [2*WIDTH-1:0] iter_res;

    assign opc       = 32'(opcode);
    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign flags     = flags_q;

    always_comb begin
        alu_lo    = '0;
        alu_hi    = '0;
        alu_cy    = 1'b0;
        alu_ill   = 1'b0;
        alu_dz    = 1'b0;
        use_iter  = 1'b0;
        iter_mode = 1'b0;
        add_sum   = {1'b0, op_a} + {1'b0, op_b};
        // Bit WIDTH of the widened shift is the last bit pushed past the top.
        shl_full  = {1'b0, op_a} << op_b[ShW-1:0];
        case (opc)
            OpAdd:  begin alu_lo = add_sum[WIDTH-1:0]; alu_cy = add_sum[WIDTH]; end
            OpSub:  begin alu_lo = op_a - op_b; alu_cy = (op_a < op_b); end
            OpNeg:  alu_lo = '0 - op_a;
            OpMul:  use_iter = 1'b1;
`ifdef SEQ_ALU_DIV_EN
            OpDiv: begin
                if (op_b == '0) begin
                    alu_lo = '1;
                    alu_hi = op_a;
                    alu_dz = 1'b1;
                end else begin
                    use_iter  = 1'b1;
                    iter_mode = 1'b1;
                end
            end
`endif
            OpOr:   alu_lo = op_a | op_b;
            OpXor:  alu_lo = op_a ^ op_b;
            OpNand: alu_lo = ~(op_a & op_b);
            OpNor:  alu_lo = ~(op_a | op_b);
            OpXnor: alu_lo = ~(op_a ^ op_b);
            OpNot:  alu_lo = ~op_a;
            OpShl:  begin alu_lo = shl_full[WIDTH-1:0]; alu_cy = shl_full[WIDTH]; end
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        flags_d    = flags_q;
        iter_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (use_iter) begin
                        iter_start = 1'b1;
                        state_d    = StCalc;
                    end else begin
                        result_d              = {alu_hi, alu_lo};
                        flags_d               = '0;
                        flags_d[FlagIllegal]  = alu_ill;
                        flags_d[FlagDivZero]  = alu_dz;
                        flags_d[FlagCarry]    = alu_cy;
                        flags_d[FlagZero]     = ({alu_hi, alu_lo} == '0);
                        state_d               = StDone;
                    end
                end
            end
            StCalc: begin
                if (iter_done) begin
                    result_d           = iter_res;
                    flags_d            = '0;
                    flags_d[FlagZero]  = (iter_res == '0);
                    state_d            = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    seq_alu_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk_i  (clk),
        .reset_i(reset),
        .start_i(iter_start),
        .mode_i (iter_mode),
        .a_i    (op_a),
        .b_i    (op_b),
        .done_o (iter_done),
        .res_o  (iter_res)
    );

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits, legal values 4..32.
REQ-002 Parameter OPW, default 6: opcode width in bits.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1: the opcode and operands are valid this cycle.
REQ-006 Port in_ready, output, 1: the block can accept an operation.
REQ-007 Port opcode, input, OPW: operation select.
REQ-008 Port op_a, input, WIDTH: first operand.
REQ-009 Port op_b, input, WIDTH: second operand.
REQ-010 Port out_valid, output, 1: a result is presented.
REQ-011 Port out_ready, input, 1: the consumer accepts the result.
REQ-012 Port result, output, 2*WIDTH: {hi, lo}; hi is zero except for MUL and DIV.
REQ-013 Port flags, output, 4: {illegal, div_zero, carry, zero}.

Function
REQ-014 Opcodes SHALL be: 0x04 ADD; 0x05 SUB (a-b); 0x06 NEG (-a); 0x07 MUL (a*b, unsigned); 0x08 DIV (lo=a/b, hi=a%b, unsigned); 0x09 OR; 0x0A XOR; 0x0B NAND; 0x0C NOR; 0x0D XNOR; 0x0E NOT (~a); 0x0F SHL (a << b[log2(WIDTH)-1:0]).
REQ-015 An operation SHALL be accepted on a cycle with in_valid && in_ready; the opcode and operands are captured then, and input changes afterwards have no effect on it.
REQ-016 The FSM SHALL have the states IDLE, CALC and DONE; in_ready is 1 only in IDLE.
REQ-017 Single-cycle operations: IDLE->DONE on acceptance; out_valid is high on the next cycle (latency 1).
REQ-018 MUL: IDLE->CALC; iterative shift-add, one bit per cycle; CALC->DONE after WIDTH cycles; latency WIDTH+1.
REQ-019 DIV: IDLE->CALC; restoring division, one bit per cycle; latency WIDTH+1.
REQ-020 DONE: result and flags SHALL be held stable while out_valid is high and out_ready is low; DONE->IDLE on out_ready.
REQ-021 There is no back-to-back bypass: at most one operation is in flight.
REQ-022 carry: carry-out for ADD; borrow (a<b) for SUB; bit shifted out beyond WIDTH for SHL; 0 otherwise.
REQ-023 zero: 1 when result == 0.
REQ-024 DIV with b == 0: no iteration; 1-cycle latency; lo = all ones; hi = a; div_zero = 1.
REQ-025 An unlisted opcode: 1-cycle latency; result = 0; illegal = 1; zero = 1.
REQ-026 in_valid while busy SHALL be ignored and never queued.
REQ-027 out_ready while out_valid is low SHALL be ignored.

Reset
REQ-028 While reset is asserted: state = IDLE; in_ready = 1; out_valid = 0; result = 0; flags = 0; all iteration registers = 0.
REQ-029 Reset in CALC or DONE SHALL abort the operation with no result and no out_valid pulse.

Configuration
REQ-030 Macro SEQ_ALU_DIV_EN defined: the DIV datapath is built and behaves per REQ-019 and REQ-024.
REQ-031 Macro SEQ_ALU_DIV_EN undefined: no divider logic; 0x08 is treated as illegal per REQ-025.

Structure
REQ-032 Package seq_alu_pkg SHALL hold: the opcode constants, the FSM state encoding, and the flag bit indices.
REQ-033 Sub-module seq_alu_iter SHALL hold the shared iterative multiply/divide datapath, with start, done and a mode bit; the divide section is guarded by SEQ_ALU_DIV_EN.

Verification (WIDTH=8)
REQ-034 Scenario: ADD a=0xF0, b=0x20 -> after 1 cycle, result=0x0010, carry=1, zero=0.
REQ-035 Scenario: MUL a=0xFF, b=0xFF -> out_valid 9 cycles after acceptance; result=0xFE01; in_ready=0 throughout.
REQ-036 Scenario: DIV a=100, b=7 -> lo=14, hi=2, latency 9; DIV a=5, b=0 -> lo=0xFF, hi=0x05, div_zero=1, latency 1.
REQ-037 Scenario: SUB a=3, b=3 with out_ready held low for 5 cycles -> result=0, zero=1, held stable; in_valid pulses during the stall are ignored.
REQ-038 Scenario: reset asserted mid-MUL (cycle 4) -> outputs immediately at their reset values; the next ADD completes correctly.
REQ-039 Scenario: opcode 0x3F -> illegal=1, result=0; with SEQ_ALU_DIV_EN undefined, opcode 0x08 -> illegal=1.
